inst_buffer: RTL and testbench

- Instruction buffer between fetch and the decoders.
- Accepts up to FETCH_WIDTH fetched 32-bit instructions (with PC) per cycle and presents up to DECODE_WIDTH oldest instructions per cycle, in program order, to the decode lanes.
- Decouples fetch from decode back-pressure; flags non-32-bit encodings (inst[1:0] != 2'b11) for the decoders to trap.
- Flushed on redirect.

---
 rtl/inst_buffer.sv | 139 +++++++++++++
 tb/tb_inst_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction queue between fetch and decode.
// Accepts up to FETCH_WIDTH instructions per cycle and presents the oldest
// DECODE_WIDTH in program order, flagging non-32-bit encodings.
// Optional macro INST_BUFFER_BYPASS_EN: when empty, incoming lanes are
// presented combinationally in the same cycle and consumed without storage.
module inst_buffer #(
    parameter int unsigned FETCH_WIDTH  = 4,
    parameter int unsigned DECODE_WIDTH = 4,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned PC_WIDTH     = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_flush,
    input  logic [FETCH_WIDTH-1:0]           i_enq_vld,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0]  i_enq_pc,
    input  logic [FETCH_WIDTH*32-1:0]        i_enq_inst,
    output logic                             o_enq_ready,
    output logic [DECODE_WIDTH-1:0]          o_deq_vld,
    output logic [DECODE_WIDTH*PC_WIDTH-1:0] o_deq_pc,
    output logic [DECODE_WIDTH*32-1:0]       o_deq_inst,
    output logic [DECODE_WIDTH-1:0]          o_deq_illegal,
    input  logic                             i_deq_ready,
    output logic [$clog2(DEPTH+1)-1:0]       o_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned INST_W = 32;
    localparam int unsigned BYP_W  = (FETCH_WIDTH < DECODE_WIDTH) ? FETCH_WIDTH : DECODE_WIDTH;

    logic [PC_WIDTH-1:0] mem_pc   [DEPTH];
    logic [INST_W-1:0]   mem_inst [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] n_wr;
    logic [CNT_W-1:0] n_deq;
    logic [CNT_W-1:0] wr_skip;
    logic             enq_ok;
    logic             deq_ok;
    logic [FETCH_WIDTH-1:0] wr_en;
    logic [PTR_W-1:0]       wr_idx [FETCH_WIDTH];

    assign o_count     = count;
    assign o_enq_ready = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign enq_ok      = o_enq_ready && (|i_enq_vld) && !i_flush;
    assign deq_ok      = i_deq_ready && (count != '0) && !i_flush;

    // Number of valid fetch lanes
    always_comb begin
        n_enq = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            n_enq = n_enq + CNT_W'(i_enq_vld[i]);
        end
    end

`ifdef INST_BUFFER_BYPASS_EN
    logic             byp_act;
    logic [CNT_W-1:0] n_byp;
    assign byp_act = (count == '0) && !i_flush && (|i_enq_vld);
    assign n_byp   = (n_enq < CNT_W'(DECODE_WIDTH)) ? n_enq : CNT_W'(DECODE_WIDTH);
    assign wr_skip = (byp_act && i_deq_ready) ? n_byp : '0;
`else
    assign wr_skip = '0;
`endif

    // Decode view: oldest entries from head, or bypassed fetch lanes when empty
    always_comb begin
        o_deq_vld     = '0;
        o_deq_pc      = '0;
        o_deq_inst    = '0;
        o_deq_illegal = '0;
        for (int unsigned j = 0; j < DECODE_WIDTH; j++) begin
            o_deq_vld[j]                       = (CNT_W'(j) < count);
            o_deq_pc[j*PC_WIDTH +: PC_WIDTH]   = mem_pc[head + PTR_W'(j)];
            o_deq_inst[j*INST_W +: INST_W]     = mem_inst[head + PTR_W'(j)];
        end
`ifdef INST_BUFFER_BYPASS_EN
        if (byp_act) begin
            for (int unsigned j = 0; j < BYP_W; j++) begin
                o_deq_vld[j]                     = i_enq_vld[j];
                o_deq_pc[j*PC_WIDTH +: PC_WIDTH] = i_enq_pc[j*PC_WIDTH +: PC_WIDTH];
                o_deq_inst[j*INST_W +: INST_W]   = i_enq_inst[j*INST_W +: INST_W];
            end
        end
`endif
        for (int unsigned j = 0; j < DECODE_WIDTH; j++) begin
            o_deq_illegal[j] = o_deq_vld[j] && (o_deq_inst[j*INST_W +: 2] != 2'b11);
        end
    end

    // Write slots, pointer advances and next occupancy
    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            wr_idx[i] = tail + PTR_W'(int'(i) - int'(wr_skip));
            wr_en[i]  = enq_ok && i_enq_vld[i] && (CNT_W'(i) >= wr_skip);
        end
        n_wr      = enq_ok ? (n_enq - wr_skip) : '0;
        n_deq     = deq_ok ? ((count < CNT_W'(DECODE_WIDTH)) ? count : CNT_W'(DECODE_WIDTH)) : '0;
        count_nxt = count + n_wr - n_deq;
    end

    // Pointer and occupancy registers; flush dominates enqueue and dequeue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_wr);
            count <= count_nxt;
        end
    end

    // Entry payload storage, not reset
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            if (wr_en[i]) begin
                mem_pc[wr_idx[i]]   <= i_enq_pc[i*PC_WIDTH +: PC_WIDTH];
                mem_inst[wr_idx[i]] <= i_enq_inst[i*INST_W +: INST_W];
            end
        end
    end

    // Fetch lanes must be contiguous from lane 0
    enq_contig_a: assert property (@(posedge clk) disable iff (rst)
        ((i_enq_vld & (i_enq_vld + FETCH_WIDTH'(1))) == '0));

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_buffer;

    localparam int FW = 4;
    localparam int DW = 4;
    localparam int DP = 16;
    localparam int PW = 64;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_flush;
    logic [FW-1:0]  i_enq_vld;
    logic [FW*PW-1:0] i_enq_pc;
    logic [FW*32-1:0] i_enq_inst;
    logic           o_enq_ready;
    logic [DW-1:0]  o_deq_vld;
    logic [DW*PW-1:0] o_deq_pc;
    logic [DW*32-1:0] o_deq_inst;
    logic [DW-1:0]  o_deq_illegal;
    logic           i_deq_ready;
    logic [4:0]     o_count;

    int checks = 0;
    int errors = 0;

    ent_t q[$];
    bit          seq_on = 1'b0;
    logic [63:0] seq_pc;
    logic [63:0] pc;

    inst_buffer #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DP), .PC_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_enq_vld(i_enq_vld), .i_enq_pc(i_enq_pc), .i_enq_inst(i_enq_inst),
        .o_enq_ready(o_enq_ready), .o_deq_vld(o_deq_vld), .o_deq_pc(o_deq_pc),
        .o_deq_inst(o_deq_inst), .o_deq_illegal(o_deq_illegal),
        .i_deq_ready(i_deq_ready), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_enq_vld   = '0;
        i_flush     = 1'b0;
        i_deq_ready = 1'b0;
    endtask

    task automatic set_enq(input int n, input logic [63:0] pc0, input logic [31:0] inst);
        i_enq_vld = FW'((1 << n) - 1);
        for (int i = 0; i < FW; i++) begin
            i_enq_pc[i*PW +: PW]   = pc0 + 64'(4 * i);
            i_enq_inst[i*32 +: 32] = inst;
        end
    endtask

    // Reference model: a FIFO of entries updated at each active edge
    always @(posedge clk or posedge rst) begin : model
        int sz, n;
        bit rdy;
        if (rst) begin
            q.delete();
        end else begin
            sz  = q.size();
            rdy = (DP - sz) >= FW;
            n   = $countones(i_enq_vld);
            if (i_flush) begin
                q.delete();
            end else begin
`ifdef INST_BUFFER_BYPASS_EN
                if (sz == 0 && n > 0 && i_deq_ready) begin
                    for (int i = DW; i < FW; i++)
                        if (i_enq_vld[i]) q.push_back({i_enq_pc[i*PW +: PW], i_enq_inst[i*32 +: 32]});
                end else
`endif
                begin
                    if (i_deq_ready)
                        for (int k = 0; k < ((sz < DW) ? sz : DW); k++) void'(q.pop_front());
                    if (rdy)
                        for (int i = 0; i < FW; i++)
                            if (i_enq_vld[i]) q.push_back({i_enq_pc[i*PW +: PW], i_enq_inst[i*32 +: 32]});
                end
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle
    always @(negedge clk) begin : cmp
        int sz, nv;
        ent_t view [DW];
        sz = q.size();
        nv = (sz < DW) ? sz : DW;
        for (int j = 0; j < DW; j++) view[j] = (j < nv) ? q[j] : '0;
`ifdef INST_BUFFER_BYPASS_EN
        if (sz == 0 && !i_flush && (|i_enq_vld)) begin
            nv = $countones(i_enq_vld);
            if (nv > DW) nv = DW;
            for (int j = 0; j < DW; j++)
                view[j] = (j < nv) ? {i_enq_pc[j*PW +: PW], i_enq_inst[j*32 +: 32]} : '0;
        end
`endif
        chk("count", 64'(o_count), 64'(sz));
        chk("enq_ready", 64'(o_enq_ready), 64'((DP - sz) >= FW));
        chk("deq_vld", 64'(o_deq_vld), 64'((1 << nv) - 1));
        for (int j = 0; j < DW; j++) begin
            chk("deq_illegal", 64'(o_deq_illegal[j]), 64'((j < nv) && (view[j].inst[1:0] != 2'b11)));
            if (j < nv) begin
                chk("deq_pc", o_deq_pc[j*PW +: PW], view[j].pc);
                chk("deq_inst", 64'(o_deq_inst[j*32 +: 32]), 64'(view[j].inst));
            end
        end
        if (seq_on && i_deq_ready && !i_flush) begin
            for (int j = 0; j < DW; j++) begin
                if (o_deq_vld[j]) begin
                    chk("seq_pc", o_deq_pc[j*PW +: PW], seq_pc);
                    seq_pc = seq_pc + 64'd4;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        i_enq_pc   = '0;
        i_enq_inst = '0;
        idle();
        step();
        chk("rst_vld", 64'(o_deq_vld), 64'h0);
        chk("rst_count", 64'(o_count), 64'h0);
        chk("rst_ready", 64'(o_enq_ready), 64'h1);
        step();
        rst = 1'b0;

        // Four lanes in, visible next cycle
        set_enq(4, 64'h1000, 32'h0000_0013);
        step();
        idle();
        #1;
        chk("t1_vld", 64'(o_deq_vld), 64'hF);
        chk("t1_count", 64'(o_count), 64'd4);
        chk("t1_pc0", o_deq_pc[0 +: PW], 64'h1000);
        chk("t1_pc3", o_deq_pc[3*PW +: PW], 64'h100C);
        chk("t1_illegal", 64'(o_deq_illegal), 64'h0);
        i_flush = 1'b1;
        step();
        idle();

        // Fill two per cycle without draining
        pc = 64'h8000;
        for (int c = 0; c < 7; c++) begin
            set_enq(2, pc, 32'h0000_0013);
            pc = pc + 64'd8;
            step();
        end
        idle();
        #1;
        chk("t2_count14", 64'(o_count), 64'd14);
        chk("t2_ready14", 64'(o_enq_ready), 64'h0);
        set_enq(2, pc, 32'h0000_0013);
        step();
        idle();
        #1;
        chk("t2_drop", 64'(o_count), 64'd14);
        i_deq_ready = 1'b1;
        step();
        idle();
        #1;
        chk("t2_count10", 64'(o_count), 64'd10);
        chk("t2_ready10", 64'(o_enq_ready), 64'h1);
        i_flush = 1'b1;
        step();
        idle();

        // Enqueue three with random decode stalls across pointer wrap
        pc     = 64'h2000;
        seq_pc = 64'h2000;
        seq_on = 1'b1;
        for (int c = 0; c < 40; c++) begin
            i_deq_ready = ($urandom_range(0, 3) != 0);
            if (o_enq_ready) begin
                set_enq(3, pc, 32'h0000_0013);
                pc = pc + 64'd12;
            end else begin
                i_enq_vld = '0;
            end
            step();
        end
        i_enq_vld   = '0;
        i_deq_ready = 1'b1;
        repeat (6) step();
        seq_on = 1'b0;
        idle();
        #1;
        chk("t3_drained", 64'(o_count), 64'h0);
        chk("t3_all_seen", seq_pc, pc);

        // Compressed encoding in lane 1
        set_enq(4, 64'h3000, 32'h0000_0013);
        i_enq_inst[32 +: 32] = 32'h0000_4501;
        step();
        idle();
        #1;
        chk("t4_illegal", 64'(o_deq_illegal), 64'h2);

        // Flush beats simultaneous enq and deq
        set_enq(2, 64'h3010, 32'h0000_0013);
        step();
        idle();
        #1;
        chk("t5_count6", 64'(o_count), 64'd6);
        set_enq(4, 64'h3018, 32'h0000_0013);
        i_deq_ready = 1'b1;
        i_flush     = 1'b1;
        step();
        idle();
        #1;
        chk("t5_count0", 64'(o_count), 64'h0);
        chk("t5_vld0", 64'(o_deq_vld), 64'h0);

        // Empty buffer, enq and deq in the same cycle
        set_enq(4, 64'h5000, 32'h0000_0013);
        i_deq_ready = 1'b1;
        #1;
`ifdef INST_BUFFER_BYPASS_EN
        chk("t6_same_vld", 64'(o_deq_vld), 64'hF);
`else
        chk("t6_same_vld", 64'(o_deq_vld), 64'h0);
`endif
        step();
        idle();
        #1;
`ifdef INST_BUFFER_BYPASS_EN
        chk("t6_count", 64'(o_count), 64'h0);
`else
        chk("t6_count", 64'(o_count), 64'd4);
`endif
        i_flush = 1'b1;
        step();
        idle();

        // Thirteen entries leaves fewer than a full group free
        pc = 64'h6000;
        for (int c = 0; c < 3; c++) begin
            set_enq(4, pc, 32'h0000_0013);
            pc = pc + 64'd16;
            step();
        end
        set_enq(1, pc, 32'h0000_0013);
        step();
        idle();
        #1;
        chk("t7_count13", 64'(o_count), 64'd13);
        chk("t7_ready13", 64'(o_enq_ready), 64'h0);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
